// File: rtl/intersection_model.sv
// Environment and checker model around the two-street traffic-light controller: per-street
// car queues drained on green, sensor outputs, and sticky protocol/overflow flags.
module intersection_model #(
  parameter int unsigned QW            = 4,
  parameter int unsigned DEPART_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arr_a,
  input  logic          arr_b,
  input  logic [1:0]    la,
  input  logic [1:0]    lb,
  output logic          ta,
  output logic          tb,
  output logic [QW-1:0] qa,
  output logic [QW-1:0] qb,
  output logic          dep_a,
  output logic          dep_b,
  output logic          ovf,
  output logic          err_seq,
  output logic          err_conflict
);

  localparam int unsigned TW = $clog2(DEPART_CYCLES) + 1;

  localparam logic [1:0] LGreen  = 2'b00;
  localparam logic [1:0] LYellow = 2'b01;
  localparam logic [1:0] LRed    = 2'b10;
  localparam logic [1:0] LBad    = 2'b11;

  localparam logic [QW-1:0] QMax  = '1;
  localparam logic [TW-1:0] TLast = TW'(DEPART_CYCLES - 1);

  // Index 0 is street A, index 1 is street B.
  logic [QW-1:0] r_q        [2];
  logic [QW-1:0] w_q_next   [2];
  logic [TW-1:0] r_tmr      [2];
  logic [TW-1:0] w_tmr_next [2];
  logic [1:0]    r_prev     [2];
  logic [1:0]    w_light    [2];
  logic [1:0]    w_arr;
  logic [1:0]    w_fire;
  logic [1:0]    r_dep;
  logic          w_ovf_evt;
  logic          w_seq_evt;
  logic          w_conf_evt;
  logic          r_ovf;
  logic          r_seq;
  logic          r_conf;

  // Legal light progression is green -> yellow -> red -> green, or holding the same code.
  function automatic logic f_legal(input logic [1:0] prev, input logic [1:0] cur);
    logic ok;
    ok = 1'b0;
    if (cur != LBad) begin
      if (cur == prev) begin
        ok = 1'b1;
      end else begin
        case (prev)
          LGreen:  ok = (cur == LYellow);
          LYellow: ok = (cur == LRed);
          LRed:    ok = (cur == LGreen);
          default: ok = 1'b0;
        endcase
      end
    end
    return ok;
  endfunction

  always_comb begin
    w_light[0] = la;
    w_light[1] = lb;
    w_arr      = {arr_b, arr_a};
    w_fire     = 2'b00;
    w_ovf_evt  = 1'b0;
    w_seq_evt  = 1'b0;
    for (int s = 0; s < 2; s++) begin
      w_tmr_next[s] = '0;
      w_q_next[s]   = r_q[s];
      if (w_light[s] == LGreen && r_q[s] != '0) begin
        if (r_tmr[s] == TLast) begin
          w_fire[s] = 1'b1;
        end else begin
          w_tmr_next[s] = r_tmr[s] + 1'b1;
        end
      end
      // A departure in the same cycle frees a slot, so an arrival at full is not dropped.
      if (w_arr[s] && !w_fire[s]) begin
        if (r_q[s] == QMax) begin
          w_ovf_evt = 1'b1;
        end else begin
          w_q_next[s] = r_q[s] + 1'b1;
        end
      end else if (!w_arr[s] && w_fire[s]) begin
        w_q_next[s] = r_q[s] - 1'b1;
      end
      if (!f_legal(r_prev[s], w_light[s])) begin
        w_seq_evt = 1'b1;
      end
    end
    w_conf_evt = (la != LRed) && (lb != LRed);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q[0]    <= '0;
      r_q[1]    <= '0;
      r_tmr[0]  <= '0;
      r_tmr[1]  <= '0;
      r_prev[0] <= LGreen;
      r_prev[1] <= LRed;
      r_dep     <= 2'b00;
      r_ovf     <= 1'b0;
      r_seq     <= 1'b0;
      r_conf    <= 1'b0;
    end else begin
      r_q[0]    <= w_q_next[0];
      r_q[1]    <= w_q_next[1];
      r_tmr[0]  <= w_tmr_next[0];
      r_tmr[1]  <= w_tmr_next[1];
      r_prev[0] <= la;
      r_prev[1] <= lb;
      r_dep     <= w_fire;
      r_ovf     <= r_ovf | w_ovf_evt;
      r_seq     <= r_seq | w_seq_evt;
      r_conf    <= r_conf | w_conf_evt;
    end
  end

  assign qa           = r_q[0];
  assign qb           = r_q[1];
  assign ta           = |r_q[0];
  assign tb           = |r_q[1];
  assign dep_a        = r_dep[0];
  assign dep_b        = r_dep[1];
  assign ovf          = r_ovf;
  assign err_seq      = r_seq;
  assign err_conflict = r_conf;

endmodule

// File: tb/tb_intersection_model.sv
// Self-checking bench for intersection_model: a cycle-level queue/flag model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_intersection_model;

  localparam int QW   = 4;
  localparam int DC   = 2;
  localparam int QMAX = (1 << QW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          arr_a = 1'b0;
  logic          arr_b = 1'b0;
  logic [1:0]    la = 2'b00;
  logic [1:0]    lb = 2'b10;
  logic          ta, tb;
  logic [QW-1:0] qa, qb;
  logic          dep_a, dep_b, ovf, err_seq, err_conflict;

  int n_chk = 0;
  int n_err = 0;

  intersection_model #(
    .QW           (QW),
    .DEPART_CYCLES(DC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .arr_a       (arr_a),
    .arr_b       (arr_b),
    .la          (la),
    .lb          (lb),
    .ta          (ta),
    .tb          (tb),
    .qa          (qa),
    .qb          (qb),
    .dep_a       (dep_a),
    .dep_b       (dep_b),
    .ovf         (ovf),
    .err_seq     (err_seq),
    .err_conflict(err_conflict)
  );

  always #5 clk = ~clk;

  // Reference model: queue lengths, green-time counters, flags.
  int mq[2];
  int mt[2];
  int mprev[2];
  bit mdep[2];
  bit movf, mseq, mconf;

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      mq[s] = 0;
      mt[s] = 0;
      mdep[s] = 1'b0;
    end
    mprev[0] = 0;
    mprev[1] = 2;
    movf = 1'b0;
    mseq = 1'b0;
    mconf = 1'b0;
  endtask

  task automatic model_step();
    int l[2];
    int a[2];
    int nq;
    int fire;
    l[0] = int'(la);
    l[1] = int'(lb);
    a[0] = int'(arr_a);
    a[1] = int'(arr_b);
    if (l[0] != 2 && l[1] != 2) mconf = 1'b1;
    for (int s = 0; s < 2; s++) begin
      fire = 0;
      if (l[s] == 0 && mq[s] > 0) begin
        mt[s] = mt[s] + 1;
        if (mt[s] == DC) begin
          fire = 1;
          mt[s] = 0;
        end
      end else begin
        mt[s] = 0;
      end
      nq = mq[s] + a[s] - fire;
      if (nq > QMAX) begin
        nq = QMAX;
        movf = 1'b1;
      end
      mq[s] = nq;
      mdep[s] = (fire != 0);
      if (l[s] == 3 ||
          (l[s] != mprev[s] && (mprev[s] == 3 || ((mprev[s] + 1) % 3) != l[s])))
        mseq = 1'b1;
      mprev[s] = l[s];
    end
  endtask

  always @(posedge reset) model_reset();

  always @(posedge clk) begin
    logic [14:0] act, exp;
    if (reset) model_reset();
    else model_step();
    #1;
    act = {ta, tb, qa, qb, dep_a, dep_b, ovf, err_seq, err_conflict};
    exp = {mq[0] != 0, mq[1] != 0, QW'(mq[0]), QW'(mq[1]), mdep[0], mdep[1], movf, mseq, mconf};
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL cycle t=%0t got %h expected %h", $time, act, exp);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs, then let n rising edges pass; returns 2 time units after the last edge.
  task automatic run(input logic a, input logic b, input logic [1:0] l_a, input logic [1:0] l_b,
                     input int n);
    arr_a = a;
    arr_b = b;
    la = l_a;
    lb = l_b;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    arr_a = 1'b0;
    arr_b = 1'b0;
    la = 2'b00;
    lb = 2'b10;
    #1 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk("reset_qa", int'(qa), 0);
    chk("reset_flags", int'({ovf, err_seq, err_conflict, dep_a, dep_b}), 0);

    // Idle with A green, B red, no cars.
    run(0, 0, 2'b00, 2'b10, 10);
    chk("idle_q", int'({qa, qb}), 0);
    chk("idle_sensors", int'({ta, tb}), 0);
    chk("idle_flags", int'({ovf, err_seq, err_conflict}), 0);

    // Queue three cars on red A, then drain on green.
    run(0, 0, 2'b01, 2'b10, 1);
    run(1, 0, 2'b10, 2'b10, 3);
    chk("fill_qa", int'(qa), 3);
    chk("fill_ta", int'(ta), 1);
    run(0, 0, 2'b00, 2'b10, 1);
    chk("green1_dep", int'(dep_a), 0);
    run(0, 0, 2'b00, 2'b10, 1);
    chk("green2_dep", int'(dep_a), 1);
    chk("green2_qa", int'(qa), 2);
    run(0, 0, 2'b00, 2'b10, 1);
    chk("green3_dep", int'(dep_a), 0);
    run(0, 0, 2'b00, 2'b10, 1);
    chk("green4_qa", int'(qa), 1);
    run(0, 0, 2'b00, 2'b10, 2);
    chk("green6_dep", int'(dep_a), 1);
    chk("green6_qa", int'(qa), 0);
    chk("green6_ta", int'(ta), 0);
    run(0, 0, 2'b00, 2'b10, 1);
    chk("green7_dep", int'(dep_a), 0);

    // Arrival coinciding with departure, then yellow discards the timer.
    run(1, 0, 2'b00, 2'b10, 1);
    run(0, 0, 2'b00, 2'b10, 1);
    run(1, 0, 2'b00, 2'b10, 1);
    chk("coinc_qa", int'(qa), 1);
    chk("coinc_dep", int'(dep_a), 1);
    run(0, 0, 2'b01, 2'b10, 3);
    chk("yellow_qa", int'(qa), 1);
    chk("yellow_dep", int'(dep_a), 0);
    run(0, 0, 2'b10, 2'b10, 1);

    // Saturate B, then departure plus arrival at full.
    run(0, 1, 2'b10, 2'b10, 15);
    chk("satb15_qb", int'(qb), 15);
    chk("satb15_ovf", int'(ovf), 0);
    run(0, 1, 2'b10, 2'b10, 1);
    chk("satb16_qb", int'(qb), 15);
    chk("satb16_ovf", int'(ovf), 1);
    run(0, 0, 2'b10, 2'b00, 1);
    run(0, 1, 2'b10, 2'b00, 1);
    chk("fullcoinc_qb", int'(qb), 15);
    chk("fullcoinc_dep", int'(dep_b), 1);
    chk("clean_seq", int'({err_seq, err_conflict}), 0);
    run(0, 0, 2'b10, 2'b00, 6);

    // Illegal sequences and conflicts.
    do_reset();
    run(0, 0, 2'b10, 2'b10, 1);
    chk("g2r_seq", int'(err_seq), 1);
    chk("g2r_conf", int'(err_conflict), 0);
    do_reset();
    run(0, 0, 2'b11, 2'b10, 1);
    chk("bad_seq", int'(err_seq), 1);
    chk("bad_conf", int'(err_conflict), 0);
    do_reset();
    run(0, 0, 2'b01, 2'b00, 1);
    chk("both_conf", int'(err_conflict), 1);
    chk("both_seq", int'(err_seq), 0);

    // Asynchronous reset mid-cycle.
    do_reset();
    run(1, 1, 2'b10, 2'b10, 5);
    run(0, 1, 2'b10, 2'b10, 11);
    chk("pre_qa", int'(qa), 5);
    chk("pre_flags", int'({ovf, err_seq}), 3);
    #3 reset = 1'b1;
    #1;
    chk("async_q", int'({qa, qb}), 0);
    chk("async_flags", int'({ovf, err_seq, err_conflict, ta, tb}), 0);
    arr_b = 1'b0;
    la = 2'b00;
    lb = 2'b10;
    @(posedge clk);
    #2 reset = 1'b0;
    run(0, 0, 2'b00, 2'b10, 5);
    chk("post_flags", int'({ovf, err_seq, err_conflict}), 0);

    // Full queue with coincident departure and arrival must not flag overflow.
    run(0, 0, 2'b01, 2'b10, 1);
    run(0, 1, 2'b10, 2'b10, 15);
    run(0, 0, 2'b10, 2'b00, 1);
    run(0, 1, 2'b10, 2'b00, 1);
    chk("fullnoovf_qb", int'(qb), 15);
    chk("fullnoovf_ovf", int'(ovf), 0);
    run(0, 0, 2'b10, 2'b00, 30);
    chk("drained_qb", int'(qb), 0);
    chk("drained_ovf", int'(ovf), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
